// File: rtl/tt_accum_pkg.sv
// Shared definitions for the accumulator ALU.
//   opcode_e  : 3-bit operation code carried on uio_in[2:0]
//   state_e   : sequencing FSM states (IDLE / EXEC / DONE)
//   ACC_W_DEFAULT, UIO_OE_MASK : default width and bidir-enable mask
package tt_accum_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_ADD    = 3'b001,
        OP_SUB    = 3'b010,
        OP_LOAD   = 3'b011,
        OP_CLEAR  = 3'b100,
        OP_ADD_HI = 3'b101,
        OP_VIEW   = 3'b110,
        OP_RSVD   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int         ACC_W_DEFAULT = 16;
    localparam logic [7:0] UIO_OE_MASK   = 8'hF0;

endpackage

// File: rtl/tt_strobe_sync.sv
// Strobe synchronizer and rising-edge detector.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   strobe     : asynchronous strobe input
//   sync_out   : strobe after SYNC_STAGES flops
//   rise       : one-cycle pulse when sync_out goes 0 -> 1
module tt_strobe_sync
    import tt_accum_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    // Both operands are flops, so the pulse is glitch-free and lasts one cycle.
    assign rise     = sync_out & ~prev_q;

endmodule

// File: rtl/tt_um_accum_alu.sv
// Strobe-driven accumulator ALU.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : unused
//   ui_in      : operand byte
//   uio_in     : [2:0] opcode, [3] strobe, [7:4] unused
//   uo_out     : acc[7:0] (view = 0) or acc[ACC_W-1:8] (view = 1)
//   uio_out    : [7] zero, [6] ovf, [5] busy, [4] done, [3:0] = 0
//   uio_oe     : constant 8'hF0
// Strobe protocol: each synchronized 0->1 transition of strobe seen in IDLE
// starts exactly one operation; opcode/operand are taken on that cycle.
// busy is high for the single EXEC cycle, done stays high until the
// synchronized strobe returns to 0. Edges seen in EXEC or DONE are dropped.
// Build option: define ACCUM_ALU_SATURATE_EN to clamp on overflow/underflow
// instead of wrapping (ovf behaves the same either way).
module tt_um_accum_alu
    import tt_accum_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEFAULT,  // 9..16
    parameter int SYNC_STAGES = 2               // 2..3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e             state_q, state_d;
    opcode_e            op_q;
    logic [7:0]         operand_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               view_q, view_d;
    logic               sync_out, rise;

    logic               unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    tt_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (uio_in[3]),
        .sync_out(sync_out),
        .rise    (rise)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rise)      state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_DONE;
            ST_DONE: if (!sync_out) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // ---------------- Operand capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NOP;
            operand_q <= 8'h00;
        end else if (state_q == ST_IDLE && rise) begin
            op_q      <= opcode_e'(uio_in[2:0]);
            operand_q <= ui_in;
        end
    end

    // ---------------- Datapath ----------------
    logic [ACC_W-1:0] opnd_lo, opnd_hi, addend;
    logic [ACC_W:0]   sum_w, diff_w;

    // ADD_HI shifts the operand up a byte; bits beyond ACC_W fall away here.
    assign opnd_lo = ACC_W'(operand_q);
    assign opnd_hi = ACC_W'({operand_q, 8'h00});
    assign addend  = (op_q == OP_ADD_HI) ? opnd_hi : opnd_lo;
    assign sum_w   = {1'b0, acc_q} + {1'b0, addend};
    assign diff_w  = {1'b0, acc_q} - {1'b0, opnd_lo};

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        view_d = view_q;
        case (op_q)
            OP_ADD, OP_ADD_HI: begin
                acc_d = sum_w[ACC_W-1:0];
                if (sum_w[ACC_W]) begin
                    ovf_d = 1'b1;
`ifdef ACCUM_ALU_SATURATE_EN
                    acc_d = '1;
`endif
                end
            end
            OP_SUB: begin
                acc_d = diff_w[ACC_W-1:0];
                // Top bit of the extended difference is the borrow.
                if (diff_w[ACC_W]) begin
                    ovf_d = 1'b1;
`ifdef ACCUM_ALU_SATURATE_EN
                    acc_d = '0;
`endif
                end
            end
            OP_LOAD:  acc_d  = opnd_lo;
            OP_CLEAR: begin
                acc_d  = '0;
                ovf_d  = 1'b0;
                view_d = 1'b0;
            end
            OP_VIEW:  view_d = ~view_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            view_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            view_q <= view_d;
        end
    end

    // ---------------- Outputs ----------------
    logic [ACC_W-1:0] acc_hi;
    assign acc_hi  = acc_q >> 8;

    assign uo_out  = view_q ? acc_hi[7:0] : acc_q[7:0];
    assign uio_out = {(acc_q == '0), ovf_q, (state_q == ST_EXEC), (state_q == ST_DONE), 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_accum_alu.sv
module tb_tt_um_accum_alu;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;
`ifdef ACCUM_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {uo_out, uio_out} at the first DONE cycle of each operation.
    logic [15:0] exp_q[$];

    logic [15:0] acc_m;
    logic        ovf_m;
    logic        view_m;

    tt_um_accum_alu #(.ACC_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [2:0] op, input logic [7:0] v);
        logic [16:0] t;
        logic [7:0]  uo_e;
        t = '0;
        case (op)
            3'b001, 3'b101: begin
                t = (op == 3'b001) ? ({1'b0, acc_m} + {9'b0, v}) : ({1'b0, acc_m} + {1'b0, v, 8'h00});
                acc_m = t[15:0];
                if (t[16]) begin
                    ovf_m = 1'b1;
                    if (SAT) acc_m = 16'hFFFF;
                end
            end
            3'b010: begin
                t = {1'b0, acc_m} - {9'b0, v};
                acc_m = t[15:0];
                if (t[16]) begin
                    ovf_m = 1'b1;
                    if (SAT) acc_m = 16'h0000;
                end
            end
            3'b011: acc_m = {8'h00, v};
            3'b100: begin
                acc_m  = 16'h0000;
                ovf_m  = 1'b0;
                view_m = 1'b0;
            end
            3'b110: view_m = ~view_m;
            default: ;
        endcase
        uo_e = view_m ? acc_m[15:8] : acc_m[7:0];
        exp_q.push_back({uo_e, (acc_m == 16'h0), ovf_m, 1'b0, 1'b1, 4'b0000});
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [7:0] v);
        @(negedge clk);
        ui_in  = v;
        uio_in = {4'b0000, 1'b1, op};
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (uio_out[4]) break;
        end
        if (!uio_out[4]) check("done_timeout", {15'b0, uio_out[4]}, 16'h1);
    endtask

    task automatic check_result(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 16'h0, 16'h1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {uo_out, uio_out}, e);
        end
    endtask

    task automatic end_op();
        uio_in[3] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!uio_out[4]) break;
        end
        check("done_clear", {15'b0, uio_out[4]}, 16'h0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] v);
        int lat;
        model_push(op, v);
        drive_op(op, v);
        wait_done(lat);
        check({tag, "_lat"}, 16'(lat), 16'(LAT));
        check_result(tag);
        end_op();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  lat;
        bit  held_ok;
        logic [2:0] r_op;
        logic [7:0] r_v;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        acc_m  = 16'h0;
        ovf_m  = 1'b0;
        view_m = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_uo",  {8'h0, uo_out},  16'h0000);
        check("rst_uio", {8'h0, uio_out}, 16'h0080);
        check("rst_oe",  {8'h0, uio_oe},  16'h00F0);
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD / ADD_HI / VIEW
        do_op("load34",  3'b011, 8'h34);
        do_op("addhi12", 3'b101, 8'h12);
        do_op("view_hi", 3'b110, 8'h00);
        do_op("view_lo", 3'b110, 8'h00);

        // Carry out of 0xFFFF
        do_op("load_ff",  3'b011, 8'hFF);
        do_op("addhi_ff", 3'b101, 8'hFF);
        do_op("add_wrap", 3'b001, 8'h01);
        do_op("clear1",   3'b100, 8'h00);

        // Borrow from 0x0005 - 0x07
        do_op("load05",   3'b011, 8'h05);
        do_op("sub07",    3'b010, 8'h07);
        do_op("clear2",   3'b100, 8'h00);

        // NOP and reserved opcode leave state untouched
        do_op("load77",   3'b011, 8'h77);
        do_op("nop",      3'b000, 8'hAB);
        do_op("rsvd",     3'b111, 8'hCD);

        // Held strobe: one increment, done window
        do_op("load00",   3'b011, 8'h00);
        model_push(3'b001, 8'h01);
        drive_op(3'b001, 8'h01);
        held_ok = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) begin
                check("held_busy",    {14'b0, uio_out[5], uio_out[4]}, 16'h0002);
            end
            if (n == 4) check_result("held_first");
            if (n > 4 && !uio_out[4]) held_ok = 1'b0;
        end
        check("held_done_stays", {15'b0, held_ok}, 16'h1);
        uio_in[3] = 1'b0;
        repeat (SYNC) @(negedge clk);
        check("held_done_tail", {15'b0, uio_out[4]}, 16'h1);
        @(negedge clk);
        check("held_done_fall", {15'b0, uio_out[4]}, 16'h0);
        check("held_once",      {8'h0, uo_out}, 16'h0001);

        // Second edge arriving in DONE is dropped
        model_push(3'b001, 8'h05);
        drive_op(3'b001, 8'h05);
        @(negedge clk);
        uio_in[3] = 1'b0;
        @(negedge clk);
        uio_in[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_result("glitch_first");
        repeat (6) @(negedge clk);
        check("glitch_ignored", {uo_out, uio_out}, 16'h0610);
        end_op();
        repeat (3) @(negedge clk);
        check("glitch_idle", {8'h0, uo_out}, 16'h0006);

        // Random operations
        for (int i = 0; i < 10; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_v  = 8'($urandom_range(0, 255));
            do_op("random", r_op, r_v);
        end

        // Reset during EXEC discards the operation
        do_op("clear3",  3'b100, 8'h00);
        do_op("load55",  3'b011, 8'h55);
        drive_op(3'b011, 8'hAA);
        repeat (3) @(negedge clk);
        check("rst_exec_busy", {15'b0, uio_out[5]}, 16'h1);
        rst_n     = 1'b0;
        uio_in[3] = 1'b0;
        #1;
        check("rst_mid_uo",  {8'h0, uo_out},  16'h0000);
        check("rst_mid_uio", {8'h0, uio_out}, 16'h0080);
        check("rst_mid_oe",  {8'h0, uio_oe},  16'h00F0);
        acc_m  = 16'h0;
        ovf_m  = 1'b0;
        view_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_late_uo",  {8'h0, uo_out},  16'h0000);
        check("rst_late_uio", {8'h0, uio_out}, 16'h0080);

        // Machine still works after the aborted operation
        do_op("post_rst", 3'b011, 8'h3C);
        check("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
